anita4_trigger_pattern_buffer: RTL and testbench

- Sits downstream of the ANITA4 simple trigger, on the receiving end of its trigger/pattern interface.
- On each new trigger it captures the 32-bit phi pattern and the 8-bit trigger count, stamps them with a free-running timestamp and a sequence number, and queues the record in a small FIFO.
- The readout logic drains records through a valid/ready port.
- Everything runs in the 250 MHz trigger domain; clock-domain crossing is done by the consumer.

---
 rtl/anita4_trig_pkg.sv | 32 +++
 rtl/anita4_trig_fifo.sv | 68 ++++++
 rtl/anita4_trigger_pattern_buffer.sv | 85 ++++++++
 tb/tb_anita4_trigger_pattern_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/anita4_trig_pkg.sv
// Shared widths and record layout for the ANITA4 trigger pattern buffer.
// Record word, MSB to LSB: {phi, count, ts, seq}.
package anita4_trig_pkg;

  localparam int NUM_PHI_DEF = 16;
  localparam int TS_W_DEF    = 16;
  localparam int DEPTH_LOG2_DEF = 3;
  localparam int CNT_W       = 8;
  localparam int SEQ_W       = 8;
  localparam int OVF_W       = 8;

  function automatic int seq_lsb();
    return 0;
  endfunction

  function automatic int ts_lsb();
    return SEQ_W;
  endfunction

  function automatic int cnt_lsb(input int ts_w);
    return SEQ_W + ts_w;
  endfunction

  function automatic int phi_lsb(input int ts_w);
    return SEQ_W + ts_w + CNT_W;
  endfunction

  function automatic int rec_w(input int num_phi, input int ts_w);
    return 2 * num_phi + CNT_W + ts_w + SEQ_W;
  endfunction

endpackage

// File: rtl/anita4_trig_fifo.sv
// First-word-fall-through FIFO; head data, empty, full and occupancy
// are all registered and describe the state after this cycle's push/pop.
module anita4_trig_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   occupancy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_n, rd_ptr_n;
  logic             wr_en, rd_en;
  logic             full_n;
  logic [WIDTH-1:0] head_n;

  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign wr_ptr_n = wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_en};
  assign rd_ptr_n = rd_ptr + {{DEPTH_LOG2{1'b0}}, rd_en};

  assign full_n =
    (wr_ptr_n[DEPTH_LOG2] != rd_ptr_n[DEPTH_LOG2]) &&
    (wr_ptr_n[DEPTH_LOG2-1:0] == rd_ptr_n[DEPTH_LOG2-1:0]);

  // New head is the word being written when it lands in the head slot
  always_comb begin
    head_n = mem[rd_ptr_n[DEPTH_LOG2-1:0]];
    if (wr_en && (rd_ptr_n == wr_ptr))
      head_n = din;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dout      <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      empty     <= (wr_ptr_n == rd_ptr_n);
      full      <= full_n;
      occupancy <= wr_ptr_n - rd_ptr_n;
      if (rd_en || empty)
        dout <= head_n;
    end
  end

endmodule

// File: rtl/anita4_trigger_pattern_buffer.sv
// Captures phi pattern and trigger count on each trigger rising edge,
// stamps them with timestamp and sequence number, and queues the record.
module anita4_trigger_pattern_buffer
  import anita4_trig_pkg::*;
#(
  parameter int NUM_PHI    = NUM_PHI_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int TS_WIDTH   = TS_W_DEF
) (
  input  logic                  clk250_i,
  input  logic                  rst_n_i,
  input  logic                  trig_i,
  input  logic [2*NUM_PHI-1:0]  phi_i,
  input  logic [CNT_W-1:0]      count_i,
  input  logic                  disable_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [2*NUM_PHI-1:0]  rd_phi_o,
  output logic [CNT_W-1:0]      rd_count_o,
  output logic [TS_WIDTH-1:0]   rd_ts_o,
  output logic [SEQ_W-1:0]      rd_seq_o,
  output logic [DEPTH_LOG2:0]   occupancy_o,
  output logic                  full_o,
  output logic [OVF_W-1:0]      overflow_count_o
);

  localparam int PHI_W   = 2 * NUM_PHI;
  localparam int REC_W   = rec_w(NUM_PHI, TS_WIDTH);
  localparam int SEQ_LSB = seq_lsb();
  localparam int TS_LSB  = ts_lsb();
  localparam int CNT_LSB = cnt_lsb(TS_WIDTH);
  localparam int PHI_LSB = phi_lsb(TS_WIDTH);

  logic                trig_q;
  logic [TS_WIDTH-1:0] ts;
  logic [SEQ_W-1:0]    seq;
  logic                cap;
  logic [REC_W-1:0]    wr_word;
  logic [REC_W-1:0]    rd_word;
  logic                fifo_empty;
  logic                fifo_full;

  assign cap     = trig_i && !trig_q && !disable_i;
  assign wr_word = {phi_i, count_i, ts, seq};

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_q           <= 1'b0;
      ts               <= '0;
      seq              <= '0;
      overflow_count_o <= '0;
    end else begin
      trig_q <= trig_i;
      ts     <= ts + 1'b1;
      // Dropped events still consume a sequence number
      if (cap)
        seq <= seq + 1'b1;
      if (cap && fifo_full && (overflow_count_o != '1))
        overflow_count_o <= overflow_count_o + 1'b1;
    end
  end

  anita4_trig_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk250_i),
    .rst_n     (rst_n_i),
    .push      (cap),
    .din       (wr_word),
    .pop       (rd_ready_i),
    .dout      (rd_word),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (occupancy_o)
  );

  assign rd_valid_o = !fifo_empty;
  assign full_o     = fifo_full;
  assign rd_phi_o   = rd_word[PHI_LSB +: PHI_W];
  assign rd_count_o = rd_word[CNT_LSB +: CNT_W];
  assign rd_ts_o    = rd_word[TS_LSB +: TS_WIDTH];
  assign rd_seq_o   = rd_word[SEQ_LSB +: SEQ_W];

endmodule

// File: tb/tb_anita4_trigger_pattern_buffer.sv
// Bench for the trigger pattern buffer: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_anita4_trigger_pattern_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] phi = '0;
  logic [7:0]  cnt = '0;
  logic        dis = 1'b0;
  logic        rdy = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_phi;
  logic [7:0]  rd_cnt;
  logic [15:0] rd_ts;
  logic [7:0]  rd_seq;
  logic [3:0]  occ;
  logic        full;
  logic [7:0]  ovf;

  always #2 clk = ~clk;

  anita4_trigger_pattern_buffer dut (
    .clk250_i         (clk),
    .rst_n_i          (rst_n),
    .trig_i           (trig),
    .phi_i            (phi),
    .count_i          (cnt),
    .disable_i        (dis),
    .rd_valid_o       (rd_valid),
    .rd_ready_i       (rdy),
    .rd_phi_o         (rd_phi),
    .rd_count_o       (rd_cnt),
    .rd_ts_o          (rd_ts),
    .rd_seq_o         (rd_seq),
    .occupancy_o      (occ),
    .full_o           (full),
    .overflow_count_o (ovf)
  );

  typedef struct {
    logic [31:0] phi;
    logic [7:0]  cnt;
    logic [15:0] ts;
    logic [7:0]  seq;
  } rec_t;

  rec_t        q[$];
  logic [15:0] m_ts;
  logic [7:0]  m_seq;
  int          m_ovf;
  logic        m_trq;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_model();
    chk("valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("occ", 64'(occ), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == 8));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (q.size() != 0) begin
      chk("phi", 64'(rd_phi), 64'(q[0].phi));
      chk("cnt", 64'(rd_cnt), 64'(q[0].cnt));
      chk("ts", 64'(rd_ts), 64'(q[0].ts));
      chk("seq", 64'(rd_seq), 64'(q[0].seq));
    end
  endtask

  task automatic model_edge();
    bit ev;
    bit was_full;
    ev = trig && !m_trq && !dis;
    was_full = (q.size() == 8);
    if (q.size() != 0 && rdy)
      void'(q.pop_front());
    if (ev) begin
      if (was_full) begin
        if (m_ovf < 255) m_ovf++;
      end else begin
        q.push_back('{phi, cnt, m_ts, m_seq});
      end
      m_seq++;
    end
    m_ts++;
    m_trq = trig;
  endtask

  task automatic step(input logic t, input logic [31:0] p,
                      input logic [7:0] c, input logic d,
                      input logic r);
    @(negedge clk);
    cmp_model();
    trig = t; phi = p; cnt = c; dis = d; rdy = r;
    @(posedge clk);
    model_edge();
  endtask

  task automatic ev(input logic r);
    step(1'b1, $urandom, 8'($urandom_range(0, 255)), 1'b0, r);
    step(1'b0, '0, '0, 1'b0, r);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, '0, '0, 1'b0, r);
  endtask

  task automatic reset_async();
    @(negedge clk);
    #1 rst_n = 1'b0;
    trig = 1'b0; dis = 1'b0; rdy = 1'b0;
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_data", {rd_phi, rd_cnt, rd_ts, rd_seq}, 64'd0);
    q.delete();
    m_ts = '0; m_seq = '0; m_ovf = 0; m_trq = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Single pulse held three cycles
    reset_async();
    while (m_ts != 16'd100) idle(1, 1'b0);
    step(1'b1, 32'h0003_0000, 8'd5, 1'b0, 1'b0);
    #1;
    chk("t1_valid", 64'(rd_valid), 64'd1);
    chk("t1_rec", {rd_phi, rd_cnt, rd_ts, rd_seq},
        {32'h0003_0000, 8'd5, 16'd100, 8'd0});
    repeat (2) step(1'b1, 32'h0003_0000, 8'd5, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    #1 chk("t1_occ", 64'(occ), 64'd1);
    idle(3, 1'b1);

    // Backpressure then back-to-back drain
    reset_async();
    repeat (3) ev(1'b0);
    #1;
    chk("t2_occ", 64'(occ), 64'd3);
    chk("t2_head", 64'(rd_seq), 64'd0);
    idle(3, 1'b0);
    idle(4, 1'b1);
    #1 chk("t2_empty", 64'(rd_valid), 64'd0);

    // Overflow, drain, seq gap visible
    reset_async();
    repeat (10) ev(1'b0);
    #1;
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_occ", 64'(occ), 64'd8);
    chk("t3_ovf", 64'(ovf), 64'd2);
    idle(8, 1'b1);
    #1 chk("t3_drained", 64'(rd_valid), 64'd0);
    ev(1'b0);
    #1 chk("t3_seq", 64'(rd_seq), 64'd10);

    // Event while full coincides with a pop
    reset_async();
    repeat (8) ev(1'b0);
    step(1'b1, 32'hdead_beef, 8'd1, 1'b0, 1'b1);
    #1;
    chk("t4_ovf", 64'(ovf), 64'd1);
    chk("t4_occ", 64'(occ), 64'd7);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Disable across a rising trigger, then saturation
    reset_async();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h1234_5678, 8'd9, 1'b1, 1'b0);
    repeat (2) step(1'b1, 32'h1234_5678, 8'd9, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    #1 chk("t5_nocap", 64'(occ), 64'd0);
    ev(1'b0);
    #1 chk("t5_seq", 64'(rd_seq), 64'd0);
    repeat (7) ev(1'b0);
    repeat (300) ev(1'b0);
    #1 chk("t5_sat", 64'(ovf), 64'd255);

    // Reset with records queued
    reset_async();
    repeat (4) ev(1'b0);
    idle(1, 1'b0);
    reset_async();
    idle(2, 1'b0);
    ev(1'b0);
    #1;
    chk("t6_seq", 64'(rd_seq), 64'd0);
    chk("t6_ts", 64'(rd_ts), 64'd2);

    // Randomized traffic, light and heavy backpressure
    reset_async();
    repeat (3000)
      step($urandom_range(0, 2) == 0, $urandom,
           8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    repeat (3000)
      step($urandom_range(0, 1) == 0, $urandom,
           8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    idle(12, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
